// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, special
// opcodes and the resident program entry points.
// The FAULT state exists only when INST_FETCH_TRAP_EN is defined.
package fetch_pkg;

    localparam logic [7:0] PROG1_BASE = 8'd0;    // multiply
    localparam logic [7:0] PROG2_BASE = 8'd98;   // string match
    localparam logic [7:0] PROG3_BASE = 8'd150;  // closest pair
    localparam logic [7:0] HALT_OP    = 8'h88;
    localparam logic [7:0] TRAP_OP    = 8'hFF;   // erased-ROM pattern

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
`ifdef INST_FETCH_TRAP_EN
        , ST_FAULT = 2'd3
`endif
    } fetch_state_e;

    // Entry point for a program select code; code 3 aliases program 1.
    function automatic logic [7:0] prog_base(input logic [1:0] sel);
        case (sel)
            2'd1:    prog_base = PROG2_BASE;
            2'd2:    prog_base = PROG3_BASE;
            default: prog_base = PROG1_BASE;
        endcase
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Control, ROM and decoder signals of the fetch unit bundled together.
// master = fetch unit, slave = surrounding control/ROM/datapath.
interface inst_fetch_if;

    logic        start_i;
    logic [1:0]  prog_sel_i;
    logic        stall_i;
    logic [7:0]  inst_i;
    logic        branch_i;
    logic        branch_back_i;
    logic [7:0]  branch_off_i;
    logic [7:0]  address_o;
    logic [7:0]  inst_o;
    logic        inst_valid_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] inst_cnt_o;

    modport master (
        input  start_i, prog_sel_i, stall_i, inst_i,
               branch_i, branch_back_i, branch_off_i,
        output address_o, inst_o, inst_valid_o, busy_o, done_o, inst_cnt_o
    );

    modport slave (
        output start_i, prog_sel_i, stall_i, inst_i,
               branch_i, branch_back_i, branch_off_i,
        input  address_o, inst_o, inst_valid_o, busy_o, done_o, inst_cnt_o
    );

endinterface

// File: rtl/pc_next.sv
// Combinational next-PC: sequential, forward branch (skip past the branch
// instruction then add the distance) or backward branch, all modulo 256.
module pc_next (
    input  logic [7:0] pc_i,
    input  logic       branch_i,
    input  logic       back_i,
    input  logic [7:0] off_i,
    output logic [7:0] pc_nxt_o
);

    // 8-bit arithmetic wraps naturally; no carry/borrow is kept.
    always_comb begin
        pc_nxt_o = pc_i + 8'd1;
        if (branch_i) begin
            if (back_i) pc_nxt_o = pc_i - off_i;
            else        pc_nxt_o = pc_i + 8'd1 + off_i;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, addresses the ROM, forwards bytes to
// the decoder and tracks run/done state and the retired instruction count.
// Optional feature: INST_FETCH_TRAP_EN (trap on opcode 8'hFF into FAULT).
module inst_fetch
    import fetch_pkg::*;
(
    input  logic           clk_i,
    input  logic           reset_i,
    inst_fetch_if.master   bus
);

    fetch_state_e state_q, state_d;
    logic [7:0]   pc_q, pc_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [7:0]   pc_nxt;
    logic         retire;
    logic         done_w;

    pc_next u_pc_next (
        .pc_i     (pc_q),
        .branch_i (bus.branch_i),
        .back_i   (bus.branch_back_i),
        .off_i    (bus.branch_off_i),
        .pc_nxt_o (pc_nxt)
    );

    // State register; reset returns every visible output to zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pc_q    <= 8'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, PC and count; halt leaves PC on the halt byte.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        retire  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!bus.stall_i) begin
`ifdef INST_FETCH_TRAP_EN
                    if (bus.inst_i == TRAP_OP) state_d = ST_FAULT;
                    else                       retire  = 1'b1;
`else
                    retire = 1'b1;
`endif
                end
            end
            default: begin
                // IDLE, DONE (and FAULT): only a start pulse does anything
                if (bus.start_i) begin
                    state_d = ST_RUN;
                    pc_d    = prog_base(bus.prog_sel_i);
                    cnt_d   = 16'd0;
                end
            end
        endcase
        if (retire) begin
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            if (bus.inst_i == HALT_OP) state_d = ST_DONE;
            else                       pc_d    = pc_nxt;
        end
    end

    // Done flag covers the fault stop as well when trapping is built in.
    always_comb begin
        done_w = (state_q == ST_DONE);
`ifdef INST_FETCH_TRAP_EN
        if (state_q == ST_FAULT) done_w = 1'b1;
`endif
    end

    assign bus.address_o    = pc_q;
    assign bus.inst_valid_o = retire;
    assign bus.inst_o       = retire ? bus.inst_i : 8'h00;
    assign bus.busy_o       = (state_q == ST_RUN);
    assign bus.done_o       = done_w;
    assign bus.inst_cnt_o   = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: ROM model, vector table for the
// branch/stall walk, expected-address queue, hand sequences for halt,
// reset and the optional trap.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_if bus();
    logic [7:0] rom [256];
    assign bus.inst_i = rom[bus.address_o];

    inst_fetch u_dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.master)
    );

    typedef struct {
        logic       start, stall, br, back;
        logic [7:0] off, cur;
        logic       vld;
        logic [7:0] nxt;
    } vec_t;

    vec_t        vecs [$];
    logic [7:0]  exp_q [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit s, input bit st, input bit b, input bit bk,
                                input int off, input int cur, input bit v, input int nxt);
        vec_t r;
        r.start = s; r.stall = st; r.br = b; r.back = bk;
        r.off = 8'(off); r.cur = 8'(cur); r.vld = v; r.nxt = 8'(nxt);
        return r;
    endfunction

    task automatic pulse_start(input logic [1:0] sel);
        @(negedge clk);
        bus.start_i = 1'b1; bus.prog_sel_i = sel;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"},  32'(bus.address_o), 0);
        check({tag, "_inst"},  32'(bus.inst_o), 0);
        check({tag, "_vld"},   32'(bus.inst_valid_o), 0);
        check({tag, "_busy"},  32'(bus.busy_o), 0);
        check({tag, "_done"},  32'(bus.done_o), 0);
        check({tag, "_cnt"},   32'(bus.inst_cnt_o), 0);
    endtask

    initial begin
        logic [7:0] ea;
        bit         seen_done;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[101] = 8'h88;
        bus.start_i = 1'b0; bus.prog_sel_i = 2'd0; bus.stall_i = 1'b0;
        bus.branch_i = 1'b0; bus.branch_back_i = 1'b0; bus.branch_off_i = 8'd0;

        repeat (2) @(posedge clk);
        #1 check_reset_vals("rst");
        @(negedge clk); rst = 1'b0;

        // program 2: 98..100 filler, halt at 101
        for (int a = 98; a <= 101; a++) exp_q.push_back(8'(a));
        pulse_start(2'd1);
        seen_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done_o) begin seen_done = 1'b1; break; end
            if (bus.inst_valid_o && exp_q.size() != 0) begin
                ea = exp_q.pop_front();
                check("p2_addr", 32'(bus.address_o), 32'(ea));
                check("p2_inst", 32'(bus.inst_o), 32'(rom[ea]));
            end
        end
        check("p2_done_seen", 32'(seen_done), 1);
        check("p2_q_empty",   32'(exp_q.size()), 0);
        check("p2_cnt",       32'(bus.inst_cnt_o), 4);
        check("p2_addr_hold", 32'(bus.address_o), 101);
        check("p2_busy",      32'(bus.busy_o), 0);
        check("p2_vld",       32'(bus.inst_valid_o), 0);
        exp_q.delete();

        // restart from DONE into program 1
        pulse_start(2'd0);
        check("rs_addr", 32'(bus.address_o), 0);
        check("rs_done", 32'(bus.done_o), 0);
        check("rs_busy", 32'(bus.busy_o), 1);
        check("rs_cnt",  32'(bus.inst_cnt_o), 0);

        //            start stall br back off  cur vld nxt
        vecs.push_back(mk(0, 0, 1, 0,  16,   0, 1,  17));
        vecs.push_back(mk(0, 0, 1, 0,   8,  17, 1,  26));
        vecs.push_back(mk(0, 1, 1, 0,   5,  26, 0,  26));
        vecs.push_back(mk(0, 1, 0, 0,   0,  26, 0,  26));
        vecs.push_back(mk(0, 1, 1, 1,   3,  26, 0,  26));
        vecs.push_back(mk(0, 0, 1, 0,  22,  26, 1,  49));
        vecs.push_back(mk(0, 0, 1, 1,  37,  49, 1,  12));
        vecs.push_back(mk(0, 0, 1, 0, 237,  12, 1, 250));
        vecs.push_back(mk(0, 0, 1, 0,  10, 250, 1,   5));
        vecs.push_back(mk(0, 0, 1, 1,   6,   5, 1, 255));
        vecs.push_back(mk(0, 0, 0, 0,   0, 255, 1,   0));
        vecs.push_back(mk(0, 0, 1, 0,  38,   0, 1,  39));
        vecs.push_back(mk(1, 0, 0, 0,   0,  39, 1,  40));

        exp_cnt = 0;
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.start_i = vecs[i].start; bus.prog_sel_i = 2'd2;
            bus.stall_i = vecs[i].stall; bus.branch_i = vecs[i].br;
            bus.branch_back_i = vecs[i].back; bus.branch_off_i = vecs[i].off;
            #1;
            check("v_vld",  32'(bus.inst_valid_o), 32'(vecs[i].vld));
            check("v_addr", 32'(bus.address_o), 32'(vecs[i].cur));
            check("v_cnt",  32'(bus.inst_cnt_o), 32'(exp_cnt));
            exp_q.push_back(vecs[i].nxt);
            if (!vecs[i].stall) exp_cnt++;
            @(posedge clk); #1;
            check("v_next", 32'(bus.address_o), 32'(exp_q.pop_front()));
        end
        bus.start_i = 1'b0; bus.stall_i = 1'b0; bus.branch_i = 1'b0;
        check("walk_cnt",  32'(bus.inst_cnt_o), 32'(exp_cnt));
        check("walk_busy", 32'(bus.busy_o), 1);

        // reset in the middle of a program at PC=40
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("mid");
        @(negedge clk); rst = 1'b0;

        // select code 3 aliases program 1
        pulse_start(2'd3);
        check("sel3_addr", 32'(bus.address_o), 0);

        // walk to 220 and present 8'hFF there
        rom[220] = 8'hFF;
        @(negedge clk);
        bus.branch_i = 1'b1; bus.branch_back_i = 1'b0; bus.branch_off_i = 8'd219;
        @(posedge clk); #1;
        bus.branch_i = 1'b0;
        check("to220", 32'(bus.address_o), 220);
        @(negedge clk);
`ifdef INST_FETCH_TRAP_EN
        check("trap_vld", 32'(bus.inst_valid_o), 0);
        check("trap_inst", 32'(bus.inst_o), 0);
        @(posedge clk); #1;
        check("trap_done", 32'(bus.done_o), 1);
        check("trap_busy", 32'(bus.busy_o), 0);
        check("trap_addr", 32'(bus.address_o), 220);
        check("trap_cnt",  32'(bus.inst_cnt_o), 1);
        repeat (2) @(posedge clk); #1;
        check("trap_hold", 32'(bus.address_o), 220);
        pulse_start(2'd2);
        check("trap_rs_addr", 32'(bus.address_o), 150);
        check("trap_rs_done", 32'(bus.done_o), 0);
`else
        check("ff_vld",  32'(bus.inst_valid_o), 1);
        check("ff_inst", 32'(bus.inst_o), 32'hFF);
        @(posedge clk); #1;
        check("ff_next", 32'(bus.address_o), 221);
        check("ff_cnt",  32'(bus.inst_cnt_o), 2);
        check("ff_busy", 32'(bus.busy_o), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit: the requesting end of the instruction ROM interface. Holds the 8-bit program counter, drives the ROM address, and hands each returned instruction byte to the decoder with a valid flag. Starts one of three resident programs on command, applies branch redirects from the datapath, and stops on the halt opcode. Sits between the top-level control (start/done) and the ROM/decoder pair.

## Interface
- PROG1_BASE, 8'd0, start address, program 1 (multiply)
- PROG2_BASE, 8'd98, start address, program 2 (string match)
- PROG3_BASE, 8'd150, start address, program 3 (closest pair)
- HALT_OP, 8'h88, halt opcode
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  start pulse (sampled in IDLE/DONE only)
- prog_sel_i  in  2  0→PROG1_BASE, 1→PROG2_BASE, 2→PROG3_BASE, 3→PROG1_BASE
- stall_i  in  1  hold PC, suppress valid
- inst_i  in  8  instruction byte from ROM (combinational on address_o)
- branch_i  in  1  branch taken for current instruction
- branch_back_i  in  1  1 = backward, 0 = forward
- branch_off_i  in  8  unsigned branch distance
- address_o  out  8  ROM address (= PC register)
- inst_o  out  8  instruction to decoder (= inst_i when valid, else 8'h00)
- inst_valid_o  out  1  inst_o is a live instruction this cycle
- busy_o  out  1  state RUN
- done_o  out  1  state DONE
- inst_cnt_o  out  16  instructions retired since last start, saturating at 16'hFFFF

## Operation
- States: IDLE, RUN, DONE (+ FAULT under macro).
- IDLE: start_i=1 → PC ← base(prog_sel_i), inst_cnt ← 0, go RUN.
- RUN, stall_i=1: PC, state, count hold; inst_valid_o=0.
- RUN, stall_i=0: inst_valid_o=1; instruction retires, inst_cnt +1 (saturating).
  - inst_i==HALT_OP → go DONE, PC holds on halt address; branch_i ignored.
  - else branch_i=1, branch_back_i=0 → PC ← PC+1+branch_off_i (mod 256).
  - else branch_i=1, branch_back_i=1 → PC ← PC−branch_off_i (mod 256).
  - else PC ← PC+1 (255 wraps to 0).
- start_i in RUN ignored.
- DONE: done_o=1 held; start_i=1 restarts exactly as from IDLE (done_o drops next cycle).
- Arithmetic 8-bit, modulo 256, no overflow flag.

## Timing
- Reset values: PC=0, state IDLE, address_o=0, inst_o=0, inst_valid_o=0, busy_o=0, done_o=0, inst_cnt_o=0.
- Reset overrides everything, including mid-program; no partial state survives.
- start_i at edge N → address_o=base at N+1, first inst_valid_o in cycle N+1.
- One instruction per non-stalled RUN cycle; branch target visible on address_o the cycle after branch_i (zero bubbles).
- Halt byte is presented with inst_valid_o=1 and counted; done_o asserts the following cycle.
- inst_o/inst_valid_o combinational from PC state and inst_i; address_o registered.

## Configuration
- INST_FETCH_TRAP_EN defined: inst_i==8'hFF (ROM unprogrammed default) in RUN, not stalled → inst_valid_o=0, not counted, go FAULT; FAULT drives busy_o=0, done_o=1, PC holds on offending address; exits only via start_i (restart) or reset.
- Undefined: 8'hFF is an ordinary instruction, no FAULT state.

## Structure
- Shared package fetch_pkg: state enum, HALT_OP and TRAP_OP constants, default program base constants.
- Sub-module pc_next: combinational next-PC (seq/forward/backward mux, mod-256 add/sub); everything else in inst_fetch.

## Test plan
- Start prog_sel=1 with ROM model holding 8'h00 at 98..100, 8'h88 at 101 → address_o 98,99,100,101; done_o next cycle; inst_cnt_o=4.
- At PC=17 branch_i=1, back=0, off=8 → next address_o=26; at PC=49 back=1, off=37 → next address_o=12.
- PC=255 no branch → address_o=0; forward off=10 at PC=250 → address_o=5.
- stall_i high 3 cycles mid-RUN → address_o frozen, inst_valid_o=0, inst_cnt_o unchanged.
- reset_i asserted in RUN at PC=40 → next cycle all outputs at reset values; start_i in RUN ignored (PC continues).
- With INST_FETCH_TRAP_EN, 8'hFF at PC=220 → inst_valid_o=0, done_o=1, address_o stays 220; start_i prog_sel=2 → address_o=150.
